// File: rtl/register_file_pkg.sv
// Shared processor constants: default datapath and register-address widths.
`default_nettype none

package register_file_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;

endpackage : register_file_pkg

`default_nettype wire

// File: rtl/register_file.sv
// register_file: NUM_REGS x DATA_W registers, two combinational read ports with write-through bypass.
// R0 is hardwired to zero. Revision 1.0.
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              write_en;

  // A write is live only for a non-zero, in-range address.
  assign write_en = reg_write && (write_reg != '0) && (int'(write_reg) < NUM_REGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    read_data_1 = '0;
    if (write_en && (read_reg_1 == write_reg)) begin
      read_data_1 = write_data;
    end else if ((read_reg_1 != '0) && (int'(read_reg_1) < NUM_REGS)) begin
      read_data_1 = regs[read_reg_1];
    end
  end

  always_comb begin
    read_data_2 = '0;
    if (write_en && (read_reg_2 == write_reg)) begin
      read_data_2 = write_data;
    end else if ((read_reg_2 != '0) && (int'(read_reg_2) < NUM_REGS)) begin
      read_data_2 = regs[read_reg_2];
    end
  end

endmodule : register_file

`default_nettype wire

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expectations.
`default_nettype none

module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [2:0]  read_reg_1;
  logic [2:0]  read_reg_2;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic [15:0] read_data_1;
  logic [15:0] read_data_2;

  int n_checks = 0;
  int n_pass   = 0;

  register_file dut (
    .clk         (clk),
    .rst         (rst),
    .reg_write   (reg_write),
    .read_reg_1  (read_reg_1),
    .read_reg_2  (read_reg_2),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [2:0] a, input logic [15:0] d);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    tick();
    reg_write  = 1'b0;
  endtask

  task automatic read_pair(input logic [2:0] a1, input logic [2:0] a2);
    read_reg_1 = a1;
    read_reg_2 = a2;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    reg_write  = 1'b0;
    read_reg_1 = '0;
    read_reg_2 = '0;
    write_reg  = '0;
    write_data = '0;
    #12;

    // Reset state on every address, both ports.
    for (int a = 0; a < 8; a++) begin
      read_pair(3'(a), 3'(7 - a));
      check($sformatf("rst_rd1_a%0d", a), read_data_1, 16'h0000);
      check($sformatf("rst_rd2_a%0d", 7 - a), read_data_2, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Write 0x1234 to R7.
    write_one(3'd7, 16'h1234);
    read_pair(3'd0, 3'd7);
    check("wr_r7_rd2", read_data_2, 16'h1234);
    check("wr_r7_rd1_r0", read_data_1, 16'h0000);

    // Writes to R0 are discarded and never forwarded.
    reg_write  = 1'b1;
    write_reg  = 3'd0;
    write_data = 16'hFFFF;
    read_pair(3'd0, 3'd0);
    check("r0_nobypass_rd1", read_data_1, 16'h0000);
    tick();
    reg_write = 1'b0;
    #1;
    check("r0_rd1", read_data_1, 16'h0000);
    check("r0_rd2", read_data_2, 16'h0000);

    // Bypass: R3 = 1, then present 0xBEEF with both ports on R3.
    write_one(3'd3, 16'h0001);
    read_pair(3'd3, 3'd3);
    check("r3_stored", read_data_1, 16'h0001);
    reg_write  = 1'b1;
    write_reg  = 3'd3;
    write_data = 16'hBEEF;
    #1;
    check("byp_pre_rd1", read_data_1, 16'hBEEF);
    check("byp_pre_rd2", read_data_2, 16'hBEEF);
    read_pair(3'd3, 3'd7);
    check("byp_indep_rd1", read_data_1, 16'hBEEF);
    check("byp_indep_rd2", read_data_2, 16'h1234);
    read_pair(3'd3, 3'd3);
    tick();
    check("byp_post_rd1", read_data_1, 16'hBEEF);
    check("byp_post_rd2", read_data_2, 16'hBEEF);
    reg_write = 1'b0;
    #1;
    check("byp_stored", read_data_2, 16'hBEEF);

    // Write enable low: R5 must stay zero.
    write_reg  = 3'd5;
    write_data = 16'hAAAA;
    repeat (3) tick();
    read_pair(3'd5, 3'd5);
    check("en_rd1", read_data_1, 16'h0000);
    check("en_rd2", read_data_2, 16'h0000);

    // Fill R1..R7 with distinct values and read them back.
    for (int a = 1; a < 8; a++) write_one(3'(a), 16'h1110 + 16'(a));
    for (int a = 1; a < 8; a++) begin
      read_pair(3'(a), 3'(8 - a));
      check($sformatf("fill_rd1_a%0d", a), read_data_1, 16'h1110 + 16'(a));
      check($sformatf("fill_rd2_a%0d", 8 - a), read_data_2, 16'h1110 + 16'(8 - a));
    end

    // Asynchronous reset between edges clears everything before the next edge.
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 8; a++) begin
      read_pair(3'(a), 3'(a));
      check($sformatf("async_rst_rd1_a%0d", a), read_data_1, 16'h0000);
      check($sformatf("async_rst_rd2_a%0d", a), read_data_2, 16'h0000);
    end

    // Write coincident with reset: forwarded while presented, but lost.
    reg_write  = 1'b1;
    write_reg  = 3'd2;
    write_data = 16'h5555;
    read_pair(3'd2, 3'd6);
    check("rst_byp_rd1", read_data_1, 16'h5555);
    check("rst_byp_rd2", read_data_2, 16'h0000);
    tick();
    reg_write = 1'b0;
    #1;
    check("rst_wr_lost", read_data_1, 16'h0000);

    // First write after reset release lands on the next edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_r2", read_data_1, 16'h0000);
    write_one(3'd4, 16'h4444);
    read_pair(3'd4, 3'd2);
    check("post_rst_wr_r4", read_data_1, 16'h4444);
    check("post_rst_r2_still0", read_data_2, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_register_file

`default_nettype wire
